// File: rtl/dtpu_ctrl_pkg.sv
// rtl/dtpu_ctrl_pkg.sv - shared state encoding, error codes and timeout defaults for the DTPU host sequencer
package dtpu_ctrl_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CSR_WR    = 3'd1;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd2;
    localparam logic [2:0] ST_START     = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_REPORT    = 3'd5;
    localparam logic [2:0] ST_ERROR     = 3'd6;

    localparam logic [1:0] ERR_NONE          = 2'd0;
    localparam logic [1:0] ERR_IDLE_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_READY_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_DONE_ABORT    = 2'd3;

    localparam int DEF_IDLE_TIMEOUT  = 64;
    localparam int DEF_START_TIMEOUT = 16;
    localparam int DEF_DONE_TIMEOUT  = 65535;

    // Timer width large enough to hold the biggest of the three limits.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dtpu_cycle_timer.sv
// rtl/dtpu_cycle_timer.sv - loadable down-counter flagging when a wait has used up its cycle budget
module dtpu_cycle_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Loading limit-1 makes the last permitted cycle of a wait read as zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= limit - WIDTH'(1);
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = enable && (count == '0);

endmodule

// File: rtl/dtpu_host_sequencer.sv
// rtl/dtpu_host_sequencer.sv - initiator side of the DTPU start/ready/done/idle control handshake
module dtpu_host_sequencer
    import dtpu_ctrl_pkg::*;
#(
    parameter int                          DATA_WIDTH_CSR   = 8,
    parameter int                          ADDRESS_SIZE_CSR = 32,
    parameter logic [ADDRESS_SIZE_CSR-1:0] CSR_CFG_ADDR     = '0,
    parameter int                          IDLE_TIMEOUT     = DEF_IDLE_TIMEOUT,
    parameter int                          START_TIMEOUT    = DEF_START_TIMEOUT,
    parameter int                          DONE_TIMEOUT     = DEF_DONE_TIMEOUT,
    parameter int                          COUNT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [DATA_WIDTH_CSR-1:0]   job_cfg,
    input  logic                        abort,
    output logic                        csr_ce,
    output logic                        csr_we,
    output logic [ADDRESS_SIZE_CSR-1:0] csr_address,
    output logic [DATA_WIDTH_CSR-1:0]   csr_din,
    output logic                        cs_start,
    input  logic                        cs_ready,
    input  logic                        cs_done,
    input  logic                        cs_idle,
    output logic                        busy,
    output logic                        job_done,
    output logic                        job_err,
    output logic [1:0]                  err_code,
    output logic [COUNT_WIDTH-1:0]      job_count
);

    localparam int TW = timer_width(IDLE_TIMEOUT, START_TIMEOUT, DONE_TIMEOUT);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [1:0]    code_next;
    logic [TW-1:0] limit_next;
    logic          job_active;
    logic          timer_clear;
    logic          timer_enable;
    logic          timer_expired;

    // REPORT and ERROR are single-cycle wrap-ups of a job already decided, so abort is not honoured there.
    assign job_active = (state == ST_CSR_WR) || (state == ST_WAIT_IDLE) ||
                        (state == ST_START)  || (state == ST_WAIT_DONE);

    always_comb begin
        state_next = state;
        code_next  = err_code;
        case (state)
            ST_IDLE: begin
                if (job_valid) begin
                    state_next = ST_CSR_WR;
                    code_next  = ERR_NONE;
                end
            end
            ST_CSR_WR: state_next = ST_WAIT_IDLE;
            ST_WAIT_IDLE: begin
                if (cs_idle) begin
                    state_next = ST_START;
                end else if (timer_expired) begin
                    state_next = ST_ERROR;
                    code_next  = ERR_IDLE_TIMEOUT;
                end
            end
            ST_START: begin
                if (cs_ready && cs_done) begin
                    state_next = ST_REPORT;
                end else if (cs_ready) begin
                    state_next = ST_WAIT_DONE;
                end else if (cs_done) begin
                    state_next = ST_ERROR;
                    code_next  = ERR_DONE_ABORT;
                end else if (timer_expired) begin
                    state_next = ST_ERROR;
                    code_next  = ERR_READY_TIMEOUT;
                end
            end
            ST_WAIT_DONE: begin
                if (cs_done) begin
                    state_next = ST_REPORT;
                end else if (timer_expired) begin
                    state_next = ST_ERROR;
                    code_next  = ERR_DONE_ABORT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort && job_active) begin
            state_next = ST_ERROR;
            code_next  = ERR_DONE_ABORT;
        end
    end

    always_comb begin
        limit_next = TW'(1);
        case (state_next)
            ST_WAIT_IDLE: limit_next = TW'(IDLE_TIMEOUT);
            ST_START:     limit_next = TW'(START_TIMEOUT);
            ST_WAIT_DONE: limit_next = TW'(DONE_TIMEOUT);
            default:      limit_next = TW'(1);
        endcase
    end

    assign timer_clear  = (state_next != state);
    assign timer_enable = (state == ST_WAIT_IDLE) || (state == ST_START) || (state == ST_WAIT_DONE);

    dtpu_cycle_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .limit  (limit_next),
        .expired(timer_expired)
    );

    // Outputs are decoded from the next state so each one is a flop aligned with its state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            job_ready   <= 1'b1;
            busy        <= 1'b0;
            csr_ce      <= 1'b0;
            csr_we      <= 1'b0;
            csr_address <= '0;
            csr_din     <= '0;
            cs_start    <= 1'b0;
            job_done    <= 1'b0;
            job_err     <= 1'b0;
            err_code    <= ERR_NONE;
            job_count   <= '0;
        end else begin
            state       <= state_next;
            err_code    <= code_next;
            job_ready   <= (state_next == ST_IDLE);
            busy        <= (state_next != ST_IDLE);
            csr_ce      <= (state_next == ST_CSR_WR);
            csr_we      <= (state_next == ST_CSR_WR);
            csr_address <= (state_next == ST_CSR_WR) ? CSR_CFG_ADDR : '0;
            csr_din     <= (state_next == ST_CSR_WR) ? job_cfg : '0;
            cs_start    <= (state_next == ST_START);
            job_done    <= (state_next == ST_REPORT);
            job_err     <= (state_next == ST_ERROR);
            if (state_next == ST_REPORT) begin
                job_count <= job_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_dtpu_host_sequencer.sv
// tb/tb_dtpu_host_sequencer.sv - self-checking bench for dtpu_host_sequencer with a reactive control-unit responder
`timescale 1ns/1ps
module tb_dtpu_host_sequencer;

    localparam int IDLE_TO  = 64;
    localparam int START_TO = 16;
    localparam int DONE_TO  = 100;
    localparam int CW       = 2;
    localparam int BIG      = 1 << 30;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          job_valid = 1'b0;
    logic [7:0]    job_cfg = 8'h00;
    logic          abort = 1'b0;
    logic          cs_ready = 1'b0;
    logic          cs_done = 1'b0;
    logic          cs_idle = 1'b0;
    logic          job_ready, csr_ce, csr_we, cs_start, busy, job_done, job_err;
    logic [31:0]   csr_address;
    logic [7:0]    csr_din;
    logic [1:0]    err_code;
    logic [CW-1:0] job_count;

    int n_cmp = 0;
    int n_bad = 0;
    int model_count = 0;

    always #5 clk = ~clk;

    dtpu_host_sequencer #(
        .DATA_WIDTH_CSR  (8),
        .ADDRESS_SIZE_CSR(32),
        .CSR_CFG_ADDR    (32'h0),
        .IDLE_TIMEOUT    (IDLE_TO),
        .START_TIMEOUT   (START_TO),
        .DONE_TIMEOUT    (DONE_TO),
        .COUNT_WIDTH     (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_cfg    (job_cfg),
        .abort      (abort),
        .csr_ce     (csr_ce),
        .csr_we     (csr_we),
        .csr_address(csr_address),
        .csr_din    (csr_din),
        .cs_start   (cs_start),
        .cs_ready   (cs_ready),
        .cs_done    (cs_done),
        .cs_idle    (cs_idle),
        .busy       (busy),
        .job_done   (job_done),
        .job_err    (job_err),
        .err_code   (err_code),
        .job_count  (job_count)
    );

    // Cycle 0 = accept cycle; predicts outcome from the responder's timing choices.
    task automatic model(input int idle_low, input int ready_at, input int dn, input int gap,
                         input int abort_gap, output int ok, output int end_c, output int code,
                         output int first, output int cnt);
        int idle_at, s, rn, d, done_c, ab_c, to_c;
        idle_at = (idle_low > 2) ? idle_low : 2;
        ok = 0; code = 0; first = -1; cnt = 0; end_c = 0;
        if (idle_at > 2 + IDLE_TO - 1) begin
            end_c = 2 + IDLE_TO;
            code  = 1;
        end else begin
            s     = idle_at + 1;
            first = s;
            rn    = (ready_at == 0) ? BIG : ready_at;
            d     = (dn == 0) ? BIG : dn;
            if (((rn < d) ? rn : d) > START_TO) begin
                cnt = START_TO; end_c = s + START_TO; code = 2;
            end else if (d < rn) begin
                cnt = d; end_c = s + d; code = 3;
            end else begin
                cnt = rn;
                if (gap == 0) begin
                    ok = 1; end_c = s + rn;
                end else begin
                    done_c = (gap < 0) ? BIG : s + rn - 1 + gap;
                    ab_c   = (abort_gap > 0) ? s + rn - 1 + abort_gap : BIG;
                    to_c   = s + rn + DONE_TO - 1;
                    if (ab_c <= done_c && ab_c <= to_c) begin
                        end_c = ab_c + 1; code = 3;
                    end else if (done_c <= to_c) begin
                        ok = 1; end_c = done_c + 1;
                    end else begin
                        end_c = to_c + 1; code = 3;
                    end
                end
            end
        end
    endtask

    task automatic run_job(input logic [7:0] cfg, input int idle_low, input int ready_at,
                           input int dn, input int gap, input int abort_gap, input bit hold,
                           input string tag, output int cnt_out);
        int e_ok, e_end, e_code, e_first, e_cnt;
        int c, w, wr_n, wr_cyc, first, cnt, rdy_cyc, end_c, end_code, code_c1;
        logic [31:0] wr_addr;
        logic [7:0]  wr_data;
        logic        got_done;
        int          end_count;
        model(idle_low, ready_at, dn, gap, abort_gap, e_ok, e_end, e_code, e_first, e_cnt);
        if (e_ok == 1) model_count = (model_count + 1) % (1 << CW);
        cnt_out = -1;
        w = 0;
        while (job_ready !== 1'b1 && w < 200) begin
            @(posedge clk); #1; w++;
        end
        n_cmp++;
        if (job_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s job_ready_wait: got %b want 1", tag, job_ready);
        end
        job_cfg = cfg; job_valid = 1'b1; cs_idle = (idle_low == 0);
        cs_ready = 1'b0; cs_done = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        if (!hold) job_valid = 1'b0;
        c = 1; wr_n = 0; wr_cyc = -1; first = -1; cnt = 0; rdy_cyc = -1; end_c = -1;
        end_code = -1; code_c1 = -1; got_done = 1'b0; end_count = -1;
        wr_addr = '0; wr_data = '0;
        while (end_c < 0 && c < 400) begin
            if (c == 1) code_c1 = int'(err_code);
            if (csr_ce && csr_we) begin
                wr_n++; wr_cyc = c; wr_addr = csr_address; wr_data = csr_din;
            end
            if (cs_start) begin
                if (first < 0) first = c;
                cnt++;
            end
            if (job_done || job_err) begin
                end_c = c; got_done = job_done; end_code = int'(err_code); end_count = int'(job_count);
                cs_ready = 1'b0; cs_done = 1'b0; abort = 1'b0;
            end else begin
                cs_idle  = (c >= idle_low);
                cs_ready = cs_start && (ready_at != 0) && (cnt == ready_at);
                if (cs_ready) rdy_cyc = c;
                cs_done  = (cs_start && !cs_ready && (dn != 0) && (cnt == dn)) ||
                           ((rdy_cyc >= 0) && (gap >= 0) && (c == rdy_cyc + gap));
                abort    = (rdy_cyc >= 0) && (abort_gap > 0) && (c == rdy_cyc + abort_gap);
                @(posedge clk); #1; c++;
            end
        end
        cnt_out = end_count;
        n_cmp++;
        if (end_c < 0) begin
            n_bad++; $display("FAIL %s completion: no job_done/job_err within 400 cycles, want end at cycle %0d", tag, e_end);
            job_valid = 1'b0;
        end else begin
            if (got_done !== e_ok[0]) begin
                n_bad++; $display("FAIL %s outcome: job_done=%b want %0d", tag, got_done, e_ok);
            end
            n_cmp++;
            if (end_c != e_end) begin
                n_bad++; $display("FAIL %s end_cycle: got %0d want %0d", tag, end_c, e_end);
            end
            n_cmp++;
            if (end_code != e_code) begin
                n_bad++; $display("FAIL %s err_code: got %0d want %0d", tag, end_code, e_code);
            end
            n_cmp++;
            if (end_count != model_count) begin
                n_bad++; $display("FAIL %s job_count: got %0d want %0d", tag, end_count, model_count);
            end
            n_cmp++;
            if (code_c1 != 0) begin
                n_bad++; $display("FAIL %s err_code_cleared: got %0d want 0", tag, code_c1);
            end
            n_cmp++;
            if (wr_n != 1 || wr_cyc != 1 || wr_addr !== 32'h0 || wr_data !== cfg) begin
                n_bad++; $display("FAIL %s csr_write: n=%0d cyc=%0d addr=%h data=%h want n=1 cyc=1 addr=0 data=%h",
                                  tag, wr_n, wr_cyc, wr_addr, wr_data, cfg);
            end
            n_cmp++;
            if (first != e_first || cnt != e_cnt) begin
                n_bad++; $display("FAIL %s cs_start: first=%0d cycles=%0d want first=%0d cycles=%0d",
                                  tag, first, cnt, e_first, e_cnt);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (job_ready !== 1'b1 || busy !== 1'b0 || job_done !== 1'b0 || job_err !== 1'b0 ||
                int'(err_code) != e_code) begin
                n_bad++; $display("FAIL %s after_end: ready=%b busy=%b done=%b err=%b code=%0d want 1 0 0 0 %0d",
                                  tag, job_ready, busy, job_done, job_err, err_code, e_code);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; job_valid = 1'b0; abort = 1'b0; cs_ready = 1'b0; cs_done = 1'b0; cs_idle = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (job_ready !== 1'b1 || busy !== 1'b0 || cs_start !== 1'b0 || csr_ce !== 1'b0 ||
            csr_we !== 1'b0 || job_done !== 1'b0 || job_err !== 1'b0 || err_code !== 2'd0 ||
            job_count !== '0 || csr_address !== 32'h0 || csr_din !== 8'h00) begin
            n_bad++; $display("FAIL reset_state: ready=%b busy=%b start=%b ce=%b we=%b done=%b err=%b code=%0d count=%0d",
                              job_ready, busy, cs_start, csr_ce, csr_we, job_done, job_err, err_code, job_count);
        end
        reset = 1'b1;
        model_count = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        int k;
        run_job(8'hA5, 0, 4, 0, 20, 0, 1'b0, "nominal", k);
    endtask

    task automatic test_ready_timeout();
        int k;
        run_job(8'h3C, 0, 0, 0, -1, 0, 1'b0, "ready_timeout", k);
    endtask

    task automatic test_idle();
        int k;
        run_job(8'h11, 12, 4, 0, 6, 0, 1'b0, "idle_wait", k);
        run_job(8'h22, 1000, 4, 0, 6, 0, 1'b0, "idle_timeout", k);
    endtask

    task automatic test_edge_events();
        int k;
        run_job(8'h5A, 0, 4, 0, 0, 0, 1'b0, "ready_done_same", k);
        run_job(8'h66, 0, 4, 2, 5, 0, 1'b0, "done_without_ready", k);
        run_job(8'h77, 0, 4, 0, -1, 0, 1'b0, "done_timeout", k);
    endtask

    task automatic test_abort();
        int k;
        run_job(8'h81, 0, 4, 0, -1, 5, 1'b0, "abort_wait_done", k);
        run_job(8'h82, 0, 4, 0, 7, 7, 1'b0, "abort_with_done", k);
    endtask

    task automatic test_reset_mid_job();
        int w;
        w = 0;
        while (job_ready !== 1'b1 && w < 200) begin
            @(posedge clk); #1; w++;
        end
        job_cfg = 8'h99; job_valid = 1'b1; cs_idle = 1'b1; cs_ready = 1'b0; cs_done = 1'b0;
        @(posedge clk); #1;
        job_valid = 1'b0;
        w = 0;
        while (cs_start !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        n_cmp++;
        if (cs_start !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid_start_reach: cs_start=%b want 1", cs_start);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_count = 0;
        n_cmp++;
        if (cs_start !== 1'b0 || busy !== 1'b0 || job_err !== 1'b0 || job_count !== '0) begin
            n_bad++; $display("FAIL reset_mid_job: start=%b busy=%b err=%b count=%0d want 0 0 0 0",
                              cs_start, busy, job_err, job_count);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (job_err !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_job_after: err=%b ready=%b busy=%b want 0 1 0", job_err, job_ready, busy);
        end
    endtask

    task automatic test_back_to_back_wrap();
        int want[5] = '{1, 2, 3, 0, 1};
        int got;
        for (int i = 0; i < 5; i++) begin
            run_job(8'(8'h10 + i), 0, 4, 0, 20, 0, (i < 4), "wrap", got);
            n_cmp++;
            if (got != want[i]) begin
                n_bad++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, got, want[i]);
            end
        end
    endtask

    task automatic test_random();
        int k, il, ra, dn, gp, ab;
        for (int i = 0; i < 25; i++) begin
            il = $urandom_range(0, 15);
            ra = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
            dn = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
            gp = $urandom_range(0, 10);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            run_job(8'($urandom), il, ra, dn, gp, ab, ((i < 24) && ($urandom_range(0, 1) == 1)), "random", k);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_ready_timeout();
        test_idle();
        test_edge_events();
        test_abort();
        test_reset_mid_job();
        test_back_to_back_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
